pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage RV32 pipeline.
- Drives forwarding selects into Execute, stalls and flushes for the F/D, D/E, E/M and M/W pipeline registers, and the load-use interlock and taken-branch flush.
- Runs a wait-state FSM for the data memory in Memory stage: req/ready handshake, timeout detection and a stall-cycle performance counter.

Parameters:
- TIMEOUT_CYCLES, 255: maximum WAIT cycles before the access is abandoned with an error; valid range 1..65535.
- CNT_W, 32: width of the stall-cycle performance counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- Rs1D, Rs2D  in  5  source registers of instruction in Decode.
- Rs1E, Rs2E  in  5  source registers of instruction in Execute.
- RdE, RdM, RdW  in  5  destination registers in Execute, Memory and Writeback.
- ResultSrcE0  in  1  1 = instruction in Execute is a load.
- RegWriteM, RegWriteW  in  1  register-write enables in Memory and Writeback.
- PCSrcE  in  1  taken branch/jump resolved in Execute.
- MemAccessM  in  1  instruction in Memory is a load or store.
- DMemReadyM  in  1  data memory completion/acknowledge.
- DMemReqM  out  1  data memory request.
- ForwardAE, ForwardBE  out  2  00 = regfile, 10 = ALUResultM, 01 = ResultW.
- StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register.
- FlushD, FlushE, FlushW  out  1  load a bubble (zeros) into the corresponding register.
- MemErr  out  1  one-cycle pulse on data-memory timeout.
- StallCount  out  CNT_W  saturating count of memory-wait stall cycles.

Behaviour:
- Reset: while reset=1:
  - all Stall*, Flush*, DMemReqM and MemErr = 0; Forward* = 00.
  - FSM goes to IDLE; timeout counter = 0; StallCount = 0.
  - Reset mid-WAIT aborts the access with no MemErr.
- Forwarding (combinational, for ForwardAE on Rs1E; same rule for ForwardBE on Rs2E):
  - 10 if RegWriteM, RdM≠0 and RdM==Rs1E.
  - else 01 if RegWriteW, RdW≠0 and RdW==Rs1E.
  - else 00.
  - M stage has priority over W.
- Load-use: lwStall = ResultSrcE0 & RdE≠0 & (RdE==Rs1D | RdE==Rs2D).
- Memory FSM, states IDLE and WAIT:
  - IDLE: DMemReqM = MemAccessM.
    - MemAccessM & DMemReadyM → zero-wait access; stay IDLE; memStall = 0.
    - MemAccessM & !DMemReadyM → go to WAIT; memStall = 1 this cycle; timeout counter = 1.
  - WAIT: DMemReqM = 1; memStall = !DMemReadyM.
    - DMemReadyM=1 → go to IDLE; pipeline advances in the same cycle.
    - Otherwise the timeout counter increments.
    - When the counter reaches TIMEOUT_CYCLES with no ready: MemErr = 1 for one cycle, memStall = 0 (instruction retires with undefined data), go to IDLE.
    - DMemReadyM arriving in the same cycle as the timeout: treated as success, MemErr = 0.
- Output composition:
  - memStall=1: StallF = StallD = StallE = StallM = 1, FlushW = 1, FlushD = FlushE = 0. Load-use and branch actions are suppressed and re-evaluated after release (E is frozen, so PCSrcE stays valid).
  - memStall=0: StallF = StallD = lwStall; StallE = StallM = 0; FlushD = PCSrcE; FlushE = lwStall | PCSrcE; FlushW = 0.
  - lwStall and PCSrcE in the same cycle: both apply; the E bubble dominates, D is flushed and F is held.
- StallCount: +1 on every cycle with memStall=1; saturates at all-ones.

Test Plan:
- Forwarding: RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 → ForwardAE=10; RdM=0, Rs1E=0 → 00; Rs2E=5 with only W matching → ForwardBE=01.
- Load-use: ResultSrcE0=1, RdE=7, Rs2D=7 → StallF=StallD=FlushE=1 for exactly one cycle; RdE=0 → no stall.
- Branch: PCSrcE=1 with lwStall=0 → FlushD=FlushE=1, StallF=0; both PCSrcE and lwStall → FlushD=FlushE=StallF=1.
- Memory wait: MemAccessM=1, DMemReadyM delayed 3 cycles → DMemReqM high 4 cycles, all Stall*=1 and FlushW=1 for 3 cycles, release on the ready cycle, StallCount=3; zero-wait access → no stall, count unchanged.
- Timeout: TIMEOUT_CYCLES=4, ready never asserted → MemErr pulses once after 4 WAIT cycles, FSM back in IDLE, stalls drop; ready on the timeout cycle → MemErr=0.
- Reset mid-WAIT and saturation: reset in cycle 2 of WAIT → all outputs 0, StallCount=0, no MemErr; CNT_W=4 with 20 stall cycles → StallCount=15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : Hazard and sequencing controller for the 5-stage RV32 pipeline.
//            Produces the Execute forwarding selects, the load-use interlock,
//            the taken-branch flush and the per-register stall/flush controls.
//            A two-state wait FSM sequences data-memory accesses in Memory,
//            with a timeout and a saturating stall-cycle counter.
// Ports    : clk, reset                  clock, synchronous active-high reset
//            Rs1D/Rs2D, Rs1E/Rs2E        source registers in Decode / Execute
//            RdE/RdM/RdW                 destinations in Execute/Memory/WB
//            ResultSrcE0                 Execute instruction is a load
//            RegWriteM/RegWriteW         register-write enables in M / W
//            PCSrcE                      taken branch/jump in Execute
//            MemAccessM, DMemReadyM      memory access request / completion
//            DMemReqM                    data-memory request
//            ForwardAE/ForwardBE         00 regfile, 10 ALUResultM, 01 ResultW
//            StallF/D/E/M, FlushD/E/W    pipeline register controls
//            MemErr                      one-cycle pulse on memory timeout
//            StallCount                  saturating memory-stall cycle count
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             ResultSrcE0,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             MemAccessM,
  input  logic             DMemReadyM,
  output logic             DMemReqM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCount
);

  localparam logic       ST_IDLE = 1'b0;
  localparam logic       ST_WAIT = 1'b1;
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);

  logic             state_q, state_d;
  logic [15:0]      tcnt_q, tcnt_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;

  logic             mem_stall;
  logic             mem_err;
  logic             mem_req;
  logic             lw_stall;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;

  // Forwarding: the younger producer (Memory) wins over Writeback.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (RegWriteM && (RdM != 5'd0) && (RdM == rs))
      return 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    fwd_a = fwd_sel(Rs1E);
    fwd_b = fwd_sel(Rs2E);
  end

  assign lw_stall = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

  // Memory wait FSM. The IDLE cycle that discovers a not-ready access counts
  // as the first timeout cycle, so WAIT starts with the counter at 1.
  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    mem_stall = 1'b0;
    mem_err   = 1'b0;
    mem_req   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        mem_req = MemAccessM;
        if (MemAccessM && !DMemReadyM) begin
          mem_stall = 1'b1;
          state_d   = ST_WAIT;
          tcnt_d    = 16'd1;
        end
      end
      default: begin
        mem_req = 1'b1;
        if (DMemReadyM) begin
          // Ready wins even on the timeout cycle.
          state_d = ST_IDLE;
          tcnt_d  = 16'd0;
        end else if (tcnt_q >= TO_LIM) begin
          // Abandon: the instruction retires with undefined load data.
          mem_err = 1'b1;
          state_d = ST_IDLE;
          tcnt_d  = 16'd0;
        end else begin
          mem_stall = 1'b1;
          tcnt_d    = tcnt_q + 16'd1;
        end
      end
    endcase
  end

  always_comb begin
    scnt_d = scnt_q;
    if (mem_stall && !(&scnt_q))
      scnt_d = scnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tcnt_q  <= 16'd0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      scnt_q  <= scnt_d;
    end
  end

  // Output composition. A memory stall freezes the whole pipe and bubbles
  // Writeback; load-use and branch actions wait until it is released (E is
  // frozen so PCSrcE is still valid then). All outputs are quiet in reset.
  always_comb begin
    DMemReqM   = !reset && mem_req;
    MemErr     = !reset && mem_err;
    ForwardAE  = reset ? 2'b00 : fwd_a;
    ForwardBE  = reset ? 2'b00 : fwd_b;
    StallF     = !reset && (mem_stall || lw_stall);
    StallD     = !reset && (mem_stall || lw_stall);
    StallE     = !reset && mem_stall;
    StallM     = !reset && mem_stall;
    FlushD     = !reset && !mem_stall && PCSrcE;
    FlushE     = !reset && !mem_stall && (lw_stall || PCSrcE);
    FlushW     = !reset && mem_stall;
    StallCount = reset ? '0 : scnt_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Purpose  : Self-checking bench for pipeline_hazard_ctrl (TIMEOUT_CYCLES=4,
//            CNT_W=4). Expected output vectors are queued as stimulus is
//            driven and compared when the outputs are sampled at negedge.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemAccessM, DMemReadyM;
  logic       DMemReqM;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  logic [3:0] StallCount;

  pipeline_hazard_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .ResultSrcE0(ResultSrcE0), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .MemAccessM(MemAccessM), .DMemReadyM(DMemReadyM),
    .DMemReqM(DMemReqM), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .MemErr(MemErr), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  int          sc    = 0;   // expected stall-cycle count (unsaturated)
  logic [16:0] exp_q[$];

  // Vector layout: {req, fwdA[1:0], fwdB[1:0], stall F,D,E,M, flush D,E,W, err, cnt[3:0]}
  function automatic logic [16:0] ev(input logic req, input logic [1:0] fa,
                                     input logic [1:0] fb, input logic [3:0] st,
                                     input logic [2:0] fl, input logic err,
                                     input logic [3:0] cnt);
    return {req, fa, fb, st, fl, err, cnt};
  endfunction

  function automatic logic [3:0] c();
    return (sc > 15) ? 4'hF : 4'(sc);
  endfunction

  task automatic check_vec(input string tag, input logic [16:0] obs, input logic [16:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %05h expected %05h", tag, obs, expv);
    end
  endtask

  task automatic step(input string tag, input logic [16:0] e);
    logic [16:0] expv;
    exp_q.push_back(e);
    @(negedge clk);
    expv = exp_q.pop_front();
    check_vec(tag, {DMemReqM, ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
                    FlushD, FlushE, FlushW, MemErr, StallCount}, expv);
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE0 = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0;
    MemAccessM = 0; DMemReadyM = 0;
  endtask

  // Four stall cycles (IDLE + three WAIT), then the timeout cycle, then idle.
  task automatic mem_timeout(input string tag, input logic rdy_at_end);
    clr();
    MemAccessM = 1;
    for (int i = 0; i < 4; i++) begin
      step(tag, ev(1, 2'b00, 2'b00, 4'hF, 3'b001, 0, c()));
      sc++;
    end
    DMemReadyM = rdy_at_end;
    step(tag, ev(1, 2'b00, 2'b00, 4'h0, 3'b000, !rdy_at_end, c()));
    clr();
    step({tag, "_idle"}, ev(0, 2'b00, 2'b00, 4'h0, 3'b000, 0, c()));
  endtask

  initial begin
    clr();
    reset = 1;
    @(posedge clk); #1;
    // Reset with active-looking inputs: everything must stay quiet.
    RdM = 5; RegWriteM = 1; Rs1E = 5; PCSrcE = 1; MemAccessM = 1;
    ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
    step("reset", ev(0, 2'b00, 2'b00, 4'h0, 3'b000, 0, 4'h0));
    reset = 0;

    clr(); RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5;
    step("fwd_m_prio", ev(0, 2'b10, 2'b00, 4'h0, 3'b000, 0, c()));
    clr(); RdM = 0; RegWriteM = 1; RdW = 0; RegWriteW = 1; Rs1E = 0;
    step("fwd_x0", ev(0, 2'b00, 2'b00, 4'h0, 3'b000, 0, c()));
    clr(); RdM = 3; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 3; Rs2E = 5;
    step("fwd_w_b", ev(0, 2'b10, 2'b01, 4'h0, 3'b000, 0, c()));
    clr(); RdM = 5; RegWriteM = 0; RdW = 5; RegWriteW = 1; Rs1E = 5;
    step("fwd_m_nowr", ev(0, 2'b01, 2'b00, 4'h0, 3'b000, 0, c()));

    clr(); ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
    step("loaduse", ev(0, 2'b00, 2'b00, 4'b1100, 3'b010, 0, c()));
    clr();
    step("loaduse_after", ev(0, 2'b00, 2'b00, 4'h0, 3'b000, 0, c()));
    clr(); ResultSrcE0 = 1; RdE = 0;
    step("loaduse_x0", ev(0, 2'b00, 2'b00, 4'h0, 3'b000, 0, c()));

    clr(); PCSrcE = 1;
    step("branch", ev(0, 2'b00, 2'b00, 4'h0, 3'b110, 0, c()));
    clr(); PCSrcE = 1; ResultSrcE0 = 1; RdE = 9; Rs1D = 9;
    step("branch_lu", ev(0, 2'b00, 2'b00, 4'b1100, 3'b110, 0, c()));

    // Three-cycle wait with a pending branch and load-use held off.
    clr(); MemAccessM = 1; PCSrcE = 1; ResultSrcE0 = 1; RdE = 9; Rs1D = 9;
    for (int i = 0; i < 3; i++) begin
      step("memwait", ev(1, 2'b00, 2'b00, 4'hF, 3'b001, 0, c()));
      sc++;
    end
    DMemReadyM = 1;
    step("memwait_rel", ev(1, 2'b00, 2'b00, 4'b1100, 3'b110, 0, c()));
    clr();
    step("memwait_cnt", ev(0, 2'b00, 2'b00, 4'h0, 3'b000, 0, 4'd3));

    clr(); MemAccessM = 1; DMemReadyM = 1;
    step("zerowait", ev(1, 2'b00, 2'b00, 4'h0, 3'b000, 0, c()));
    clr();
    step("zerowait_cnt", ev(0, 2'b00, 2'b00, 4'h0, 3'b000, 0, 4'd3));

    mem_timeout("timeout", 1'b0);
    mem_timeout("rdy_on_to", 1'b1);

    // Reset in the second WAIT cycle.
    clr(); MemAccessM = 1;
    for (int i = 0; i < 2; i++) begin
      step("rst_wait", ev(1, 2'b00, 2'b00, 4'hF, 3'b001, 0, c()));
      sc++;
    end
    reset = 1;
    step("rst_mid", ev(0, 2'b00, 2'b00, 4'h0, 3'b000, 0, 4'h0));
    sc = 0;
    reset = 0; clr();
    step("rst_idle", ev(0, 2'b00, 2'b00, 4'h0, 3'b000, 0, 4'h0));

    for (int k = 0; k < 5; k++) mem_timeout("sat", 1'b0);
    step("sat_final", ev(0, 2'b00, 2'b00, 4'h0, 3'b000, 0, 4'hF));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
